mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares the single-port `memory` block between the instruction-fetch requester and the load/store requester of the core. At most one access per cycle: it selects a winner, drives the memory port, and returns responses registered one cycle later. Misaligned data accesses are rejected with an error response instead of reaching memory. A starvation counter ensures fetch progress under continuous load/store traffic.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive cycles fetch may lose to data before fetch is forced to win. Legal range 1..15.
- CNT_W, 4: width of the starvation counter. Must satisfy 2**CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  fetch request pending.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_addr  in  32  fetch byte address.
- if_rsp_valid  out  1  one-cycle pulse carrying the fetch response.
- if_rsp_data  out  32  fetched instruction word.
- if_rsp_err  out  1  fetch address not word-aligned.
- d_req_valid  in  1  data request pending.
- d_req_ready  out  1  data request accepted this cycle.
- d_we  in  1  1 = store, 0 = load.
- d_nbyte  in  2  00 word, 01 byte, 10 half; 11 illegal.
- d_unsigned  in  1  zero-extend loads.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rsp_valid  out  1  one-cycle pulse carrying the data response.
- d_rsp_data  out  32  load result; 0 for stores and errors.
- d_rsp_err  out  1  misaligned or illegal nbyte.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_nbyte  out  2  to memory NByteOp.
- mem_unsigned  out  1  to memory Unsigned.
- mem_addr  out  32  to memory addr.
- mem_wdata  out  32  to memory write_data.
- mem_rdata  in  32  from memory read_data; combinational in the same cycle as mem_read.

Behaviour:
- Grant is combinational, with one grant per cycle:
  - grant_d = d_req_valid and not force_if.
  - grant_if = if_req_valid and not grant_d.
  - force_if = if_req_valid and (starve_cnt == STARVE_LIMIT).
- if_req_ready = grant_if and d_req_ready = grant_d. Ready may depend on valid. Requesters must not make valid depend on ready.
- Memory drive in the grant cycle:
  - Data grant that is aligned: mem_read = !d_we, mem_write = d_we, and the remaining memory fields come from the d_* inputs.
  - Fetch grant that is aligned: mem_read = 1, mem_nbyte = 00, mem_unsigned = 0, mem_addr = if_addr.
  - No grant, or an error grant: mem_read = mem_write = 0 and every mem_* field = 0.
- Alignment rules:
  - Word requires addr[1:0] = 00.
  - Half requires addr[0] = 0.
  - Byte is always legal.
  - nbyte = 11 is always an error.
  - An error request is still accepted (ready = 1) and consumes the slot.
- Response, latency 1:
  - At the posedge ending a grant cycle, the winner's rsp_valid <= 1, rsp_data <= mem_rdata (0 for stores and errors), and rsp_err <= error flag.
  - The non-winner's rsp_valid <= 0.
  - Responses have no backpressure: a pulse lasts exactly one cycle and requesters must capture it.
  - Back-to-back grants give back-to-back pulses.
- Starvation counter (starve_cnt):
  - Increments when grant_d and if_req_valid are both 1.
  - Clears to 0 when grant_if = 1 or if_req_valid = 0.
  - Saturates at STARVE_LIMIT; it never wraps.
- State is intentionally minimal: starve_cnt, the response registers, and a 2-state last-winner enum (GNT_IF / GNT_D) used only for debug.
- Reset:
  - While rst = 1, all grants are forced to 0 combinationally, so mem_write = 0 during reset.
  - Every *_rsp_* output and starve_cnt reset to 0; last-winner resets to GNT_IF.
  - A reset asserted mid-grant drops that response; the store is suppressed if rst is high before the posedge.
- Simultaneous requests with starve_cnt < STARVE_LIMIT: data wins. At the limit: fetch wins and starve_cnt clears.

Decomposition:
- mem_pkg holds:
  - typedef nbyte_t and constants NBYTE_WORD = 2'b00, NBYTE_BYTE = 2'b01, NBYTE_HALF = 2'b10.
  - enum grant_e {GNT_IF, GNT_D}.
  - function is_misaligned(nbyte, addr[1:0]), shared with the memory-stage decoder.
- No sub-module. The grant logic, counter and response registers stay in one module.

Test Plan:
- Single fetch, if_addr = 0x100, memory word 0x00A00093 → if_req_ready = 1 the same cycle; next cycle if_rsp_valid = 1, if_rsp_data = 0x00A00093, if_rsp_err = 0.
- Both valid with starve_cnt = 0, data lw 0x200 = 0xDEADBEEF → d_req_ready = 1 and if_req_ready = 0; next cycle d_rsp_data = 0xDEADBEEF; the fetch is granted in cycle 2.
- Data valid continuously and fetch valid, STARVE_LIMIT = 4 → data wins cycles 0–3; fetch wins cycle 4 (starve_cnt = 4); data wins cycle 5 with starve_cnt = 0.
- sh to 0x203 → accepted; mem_write = 0 throughout; next cycle d_rsp_err = 1, d_rsp_data = 0; memory unchanged.
- sb 0x12345678 to 0x301, then lbu 0x301 → mem_write pulses with nbyte = 01; the lbu response = 0x00000078.
- rst asserted mid-cycle during a sw grant to 0x400 → mem_write drops to 0 immediately; no response pulse; memory at 0x400 unchanged; all outputs 0 until release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for memory-port sharing: access-size encodings, grant
// identities and the alignment rule used by the arbiter and the memory-stage decoder.
package mem_pkg;

  typedef logic [1:0] nbyte_t;

  localparam nbyte_t NBYTE_WORD = 2'b00;
  localparam nbyte_t NBYTE_BYTE = 2'b01;
  localparam nbyte_t NBYTE_HALF = 2'b10;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

  // nbyte = 11 has no legal meaning, so it is always reported as an error.
  function automatic logic is_misaligned(input nbyte_t nbyte, input logic [1:0] addr_lo);
    case (nbyte)
      NBYTE_WORD: return (addr_lo != 2'b00);
      NBYTE_HALF: return addr_lo[0];
      NBYTE_BYTE: return 1'b0;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch and load/store request/response channels together with the
// single-port memory connection that the arbiter drives.
interface mem_arbiter_if
  import mem_pkg::*;
();

  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;

  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_we;
  nbyte_t      d_nbyte;
  logic        d_unsigned;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;

  logic        mem_read;
  logic        mem_write;
  nbyte_t      mem_nbyte;
  logic        mem_unsigned;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  grant_e      last_gnt;

  modport slave (
    input  if_req_valid, if_addr,
    input  d_req_valid, d_we, d_nbyte, d_unsigned, d_addr, d_wdata,
    input  mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output mem_read, mem_write, mem_nbyte, mem_unsigned, mem_addr, mem_wdata,
    output last_gnt
  );

  modport master (
    output if_req_valid, if_addr,
    output d_req_valid, d_we, d_nbyte, d_unsigned, d_addr, d_wdata,
    output mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  mem_read, mem_write, mem_nbyte, mem_unsigned, mem_addr, mem_wdata,
    input  last_gnt
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: one access per cycle, data priority with a
// starvation guard for fetch, misaligned accesses answered with an error pulse.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_nxt;
  grant_e           r_last;
  grant_e           w_last_nxt;

  logic w_force_if;
  logic w_grant_d;
  logic w_grant_if;
  logic w_d_err;
  logic w_if_err;

  logic        r_if_rsp_valid;
  logic [31:0] r_if_rsp_data;
  logic        r_if_rsp_err;
  logic        r_d_rsp_valid;
  logic [31:0] r_d_rsp_data;
  logic        r_d_rsp_err;

  // Gating grants with rst keeps a store from reaching memory once reset rises.
  always_comb begin
    w_force_if = bus.if_req_valid && (r_starve_cnt == LIMIT);
    w_grant_d  = !rst && bus.d_req_valid && !w_force_if;
    w_grant_if = !rst && bus.if_req_valid && !w_grant_d;
    w_d_err    = is_misaligned(bus.d_nbyte, bus.d_addr[1:0]);
    w_if_err   = (bus.if_addr[1:0] != 2'b00);
  end

  always_comb begin
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_nbyte    = NBYTE_WORD;
    bus.mem_unsigned = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    if (w_grant_d && !w_d_err) begin
      bus.mem_read     = !bus.d_we;
      bus.mem_write    = bus.d_we;
      bus.mem_nbyte    = bus.d_nbyte;
      bus.mem_unsigned = bus.d_unsigned;
      bus.mem_addr     = bus.d_addr;
      bus.mem_wdata    = bus.d_wdata;
    end else if (w_grant_if && !w_if_err) begin
      bus.mem_read = 1'b1;
      bus.mem_addr = bus.if_addr;
    end
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_grant_if || !bus.if_req_valid) begin
      w_starve_nxt = '0;
    end else if (w_grant_d && (r_starve_cnt != LIMIT)) begin
      w_starve_nxt = r_starve_cnt + 1'b1;
    end
  end

  always_comb begin
    w_last_nxt = r_last;
    if (w_grant_d) begin
      w_last_nxt = GNT_D;
    end else if (w_grant_if) begin
      w_last_nxt = GNT_IF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_last       <= GNT_IF;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_last       <= w_last_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_rsp_valid <= 1'b0;
      r_if_rsp_data  <= '0;
      r_if_rsp_err   <= 1'b0;
      r_d_rsp_valid  <= 1'b0;
      r_d_rsp_data   <= '0;
      r_d_rsp_err    <= 1'b0;
    end else begin
      r_if_rsp_valid <= w_grant_if;
      r_if_rsp_err   <= w_grant_if && w_if_err;
      r_if_rsp_data  <= (w_grant_if && !w_if_err) ? bus.mem_rdata : '0;
      r_d_rsp_valid  <= w_grant_d;
      r_d_rsp_err    <= w_grant_d && w_d_err;
      r_d_rsp_data   <= (w_grant_d && !w_d_err && !bus.d_we) ? bus.mem_rdata : '0;
    end
  end

  always_comb begin
    bus.if_req_ready = w_grant_if;
    bus.d_req_ready  = w_grant_d;
    bus.if_rsp_valid = r_if_rsp_valid;
    bus.if_rsp_data  = r_if_rsp_data;
    bus.if_rsp_err   = r_if_rsp_err;
    bus.d_rsp_valid  = r_d_rsp_valid;
    bus.d_rsp_data   = r_d_rsp_data;
    bus.d_rsp_err    = r_d_rsp_err;
    bus.last_gnt     = r_last;
  end

endmodule
